// File: rtl/rv32i_types.sv
// Shared types for the RV32I memory subsystem: machine word, cacheline,
// and the state and grant encodings used by the I/D memory arbiter.
package rv32i_types;

  // Machine word; every address port carries one of these.
  typedef logic [31:0] rv32i_word;

  // Default cacheline width and the matching line type.
  localparam int unsigned LINE_W_DEFAULT = 256;
  typedef logic [LINE_W_DEFAULT-1:0] line_t;

  // Arbiter FSM states. The busy state also records which client owns
  // the adaptor, so the state register doubles as the granted-client latch.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  // Client identity for round-robin bookkeeping and the response select.
  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Two-client cacheline arbiter placed between the I-cache / D-cache and the
// cacheline adaptor. One transaction is in flight at a time. Simultaneous
// requests are resolved round-robin. Every output comes straight from a
// register, so the adaptor and both caches see glitch-free strobes.
import rv32i_types::*;

module pmem_arbiter #(
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,

  input  rv32i_word         i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  rv32i_word         d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output rv32i_word         mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_r;
  grant_t            last_grant_r;
  grant_t            client_r;
  rv32i_word         addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic [LINE_W-1:0] line_buf_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic              i_resp_r;
  logic              d_resp_r;

  logic              req_i_s;
  logic              req_d_s;
  logic              grant_i_s;
  logic              grant_d_s;

  // Decide which client, if any, wins the adaptor on this IDLE cycle.
  always_comb begin
    req_i_s   = i_read;
    req_d_s   = d_read | d_write;
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      if (req_i_s && req_d_s) begin
        // Tie: serve whichever client did not get the previous grant.
        if (last_grant_r == GRANT_D) begin
          grant_i_s = 1'b1;
        end else begin
          grant_d_s = 1'b1;
        end
      end else if (req_i_s) begin
        grant_i_s = 1'b1;
      end else if (req_d_s) begin
        grant_d_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
      end
    end else begin
      // Busy or responding: requests are ignored until we are back in IDLE.
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // FSM, request latching, line buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= GRANT_D;
      client_r     <= GRANT_D;
      addr_r       <= 32'h0000_0000;
      wdata_r      <= {LINE_W{1'b0}};
      line_buf_r   <= {LINE_W{1'b0}};
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      i_resp_r     <= 1'b0;
      d_resp_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          i_resp_r <= 1'b0;
          d_resp_r <= 1'b0;
          if (grant_i_s) begin
            state_r      <= I_BUSY;
            last_grant_r <= GRANT_I;
            client_r     <= GRANT_I;
            addr_r       <= i_address;
            wdata_r      <= {LINE_W{1'b0}};
            mem_read_r   <= 1'b1;
            mem_write_r  <= 1'b0;
          end else if (grant_d_s) begin
            state_r      <= D_BUSY;
            last_grant_r <= GRANT_D;
            client_r     <= GRANT_D;
            addr_r       <= d_address;
            wdata_r      <= d_wdata;
            // A simultaneous read and write request is a writeback.
            mem_read_r   <= ~d_write;
            mem_write_r  <= d_write;
          end else begin
            state_r     <= IDLE;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
          end
        end

        I_BUSY, D_BUSY: begin
          // Address, data and strobes hold until the adaptor completes.
          if (mem_resp) begin
            state_r     <= RESP;
            line_buf_r  <= mem_rdata;
            mem_read_r  <= 1'b0;
            mem_write_r <= 1'b0;
            i_resp_r    <= (client_r == GRANT_I);
            d_resp_r    <= (client_r == GRANT_D);
          end else begin
            state_r <= state_r;
          end
        end

        RESP: begin
          // The completion pulse lasts exactly this one cycle.
          state_r  <= IDLE;
          i_resp_r <= 1'b0;
          d_resp_r <= 1'b0;
        end

        default: begin
          state_r     <= IDLE;
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          i_resp_r    <= 1'b0;
          d_resp_r    <= 1'b0;
        end
      endcase
    end
  end

  // Both clients see the same line buffer; only their resp marks it valid.
  assign i_rdata     = line_buf_r;
  assign d_rdata     = line_buf_r;
  assign i_resp      = i_resp_r;
  assign d_resp      = d_resp_r;
  assign mem_address = addr_r;
  assign mem_read    = mem_read_r;
  assign mem_write   = mem_write_r;
  assign mem_wdata   = wdata_r;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: single read, tie resolution,
// alternating round-robin, writeback stability, reset mid-transaction,
// read+write collision and a stray adaptor response.
module tb_pmem_arbiter;
  import rv32i_types::*;

  localparam int LINE_W = 256;

  logic              clk;
  logic              rst;
  rv32i_word         i_address;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  rv32i_word         d_address;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  rv32i_word         mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  int checks;
  int errors;

  logic [LINE_W-1:0] pat_a5;
  logic [LINE_W-1:0] pat_wb;
  logic [LINE_W-1:0] pat_x;

  pmem_arbiter #(.LINE_W(LINE_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_address   (i_address),
    .i_read      (i_read),
    .i_rdata     (i_rdata),
    .i_resp      (i_resp),
    .d_address   (d_address),
    .d_read      (d_read),
    .d_write     (d_write),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_resp      (d_resp),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Adaptor completes in the current cycle with the given line.
  task automatic respond(input logic [LINE_W-1:0] data);
    mem_rdata = data;
    mem_resp  = 1'b1;
    tick();
    mem_resp  = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pat_a5    = {32{8'hA5}};
    pat_wb    = {8{32'h1234_5678}};
    pat_x     = {16{16'h3C3C}};
    rst       = 1'b1;
    i_address = 32'h0000_0000;
    i_read    = 1'b0;
    d_address = 32'h0000_0000;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_wdata   = {LINE_W{1'b0}};
    mem_rdata = {LINE_W{1'b0}};
    mem_resp  = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_address", mem_address, 32'h0);
    chk("rst_i_resp", i_resp, 1'b0);
    chk("rst_d_resp", d_resp, 1'b0);
    chk("rst_rdata", i_rdata, {LINE_W{1'b0}});

    // Single I read, request dropped while busy
    rst       = 1'b0;
    i_read    = 1'b1;
    i_address = 32'h0000_0060;
    tick();
    chk("rd_mem_read", mem_read, 1'b1);
    chk("rd_mem_write", mem_write, 1'b0);
    chk("rd_mem_address", mem_address, 32'h0000_0060);
    i_read = 1'b0;
    tick();
    tick();
    tick();
    chk("rd_mem_read_hold", mem_read, 1'b1);
    chk("rd_no_early_resp", i_resp, 1'b0);
    respond(pat_a5);
    chk("rd_i_resp", i_resp, 1'b1);
    chk("rd_i_rdata", i_rdata, pat_a5);
    chk("rd_d_resp", d_resp, 1'b0);
    chk("rd_strobe_drop", mem_read, 1'b0);
    tick();
    chk("rd_i_resp_end", i_resp, 1'b0);

    // Tie at reset exit: I first, then D right after one IDLE cycle
    rst       = 1'b1;
    i_read    = 1'b1;
    d_read    = 1'b1;
    i_address = 32'h0000_0100;
    d_address = 32'h0000_0200;
    tick();
    rst = 1'b0;
    tick();
    chk("tie_first_addr", mem_address, 32'h0000_0100);
    chk("tie_first_read", mem_read, 1'b1);
    i_read = 1'b0;
    respond(pat_x);
    chk("tie_i_resp", i_resp, 1'b1);
    chk("tie_d_resp_quiet", d_resp, 1'b0);
    tick();
    chk("tie_idle_strobe", mem_read, 1'b0);
    tick();
    chk("tie_second_addr", mem_address, 32'h0000_0200);
    chk("tie_second_read", mem_read, 1'b1);
    d_read = 1'b0;
    respond(pat_a5);
    chk("tie_d_resp", d_resp, 1'b1);
    chk("tie_d_rdata", d_rdata, pat_a5);
    chk("tie_i_resp_quiet", i_resp, 1'b0);
    tick();

    // Four ties held continuously: grants alternate I, D, I, D
    i_read    = 1'b1;
    d_read    = 1'b1;
    i_address = 32'h0000_0300;
    d_address = 32'h0000_0400;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_addr", mem_address, (k % 2 == 0) ? 32'h0000_0300 : 32'h0000_0400);
      respond(pat_x);
      chk("rr_i_resp", i_resp, (k % 2 == 0) ? 1'b1 : 1'b0);
      chk("rr_d_resp", d_resp, (k % 2 == 0) ? 1'b0 : 1'b1);
      if (k == 3) begin
        i_read = 1'b0;
        d_read = 1'b0;
      end
      tick();
    end
    chk("rr_idle_read", mem_read, 1'b0);

    // D writeback with inputs changed during BUSY
    d_write   = 1'b1;
    d_address = 32'h8000_0100;
    d_wdata   = pat_wb;
    tick();
    chk("wb_mem_write", mem_write, 1'b1);
    chk("wb_mem_read", mem_read, 1'b0);
    chk("wb_addr", mem_address, 32'h8000_0100);
    chk("wb_wdata", mem_wdata, pat_wb);
    d_write   = 1'b0;
    d_address = 32'hDEAD_0000;
    d_wdata   = {LINE_W{1'b0}};
    tick();
    tick();
    chk("wb_write_hold", mem_write, 1'b1);
    chk("wb_addr_hold", mem_address, 32'h8000_0100);
    chk("wb_wdata_hold", mem_wdata, pat_wb);
    respond(pat_x);
    chk("wb_d_resp", d_resp, 1'b1);
    chk("wb_i_resp", i_resp, 1'b0);
    chk("wb_write_drop", mem_write, 1'b0);
    tick();
    chk("wb_d_resp_once", d_resp, 1'b0);

    // Reset during D_BUSY with a coincident adaptor response
    d_read    = 1'b1;
    d_address = 32'h0000_0040;
    tick();
    chk("rb_mem_read", mem_read, 1'b1);
    d_read = 1'b0;
    tick();
    rst       = 1'b1;
    mem_resp  = 1'b1;
    mem_rdata = {LINE_W{1'b1}};
    tick();
    chk("rb_mem_read_clr", mem_read, 1'b0);
    chk("rb_addr_clr", mem_address, 32'h0);
    chk("rb_d_resp", d_resp, 1'b0);
    chk("rb_i_resp", i_resp, 1'b0);
    chk("rb_rdata_clr", d_rdata, {LINE_W{1'b0}});
    rst      = 1'b0;
    mem_resp = 1'b0;
    tick();
    chk("rb_d_resp_after", d_resp, 1'b0);
    i_read    = 1'b1;
    i_address = 32'h0000_0500;
    tick();
    chk("rb_next_addr", mem_address, 32'h0000_0500);
    chk("rb_next_read", mem_read, 1'b1);
    i_read = 1'b0;
    respond(pat_a5);
    chk("rb_next_i_resp", i_resp, 1'b1);
    chk("rb_next_rdata", i_rdata, pat_a5);
    tick();

    // d_read and d_write together behave as a write
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 32'h0000_0600;
    d_wdata   = pat_x;
    tick();
    chk("rw_mem_write", mem_write, 1'b1);
    chk("rw_mem_read", mem_read, 1'b0);
    d_read  = 1'b0;
    d_write = 1'b0;
    tick();
    chk("rw_mem_read_hold", mem_read, 1'b0);
    respond(pat_wb);
    chk("rw_d_resp", d_resp, 1'b1);
    tick();

    // Stray adaptor response while IDLE is ignored
    mem_rdata = pat_x;
    mem_resp  = 1'b1;
    tick();
    mem_resp = 1'b0;
    chk("stray_i_resp", i_resp, 1'b0);
    chk("stray_d_resp", d_resp, 1'b0);
    chk("stray_rdata", d_rdata, pat_wb);
    tick();
    chk("stray_idle", mem_read, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
